// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port, one
// transaction in flight, with a starvation bound on the instruction side.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CntW = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            lock_q, lock_d;
    logic            lock_data_q, lock_data_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic sel_data;
    logic any_req;

    assign any_req = i_req | d_req;

    // A latched owner holds the selection until its handshake completes.
    always_comb begin
        if (lock_q) begin
            sel_data = lock_data_q;
        end else if (i_req && d_req) begin
            sel_data = (starve_q < Limit);
        end else begin
            sel_data = d_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        lock_data_d = lock_data_q;
        starve_d    = starve_q;
        case (state_q)
            IDLE: begin
                if (any_req && m_gnt) begin
                    state_d = sel_data ? BUSY_D : BUSY_I;
                    lock_d  = 1'b0;
                    if (sel_data && i_req) begin
                        if (starve_q < Limit) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else if (any_req) begin
                    lock_d      = 1'b1;
                    lock_data_d = sel_data;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_q      <= 1'b0;
            lock_data_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            lock_data_q <= lock_data_d;
            starve_q    <= starve_d;
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = '0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (!reset) begin
            i_rdata = m_rdata;
            d_rdata = m_rdata;
            case (state_q)
                IDLE: begin
                    m_req = any_req;
                    if (sel_data) begin
                        m_we    = d_we;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        m_be    = d_be;
                        d_gnt   = any_req & m_gnt;
                    end else begin
                        m_addr  = i_addr;
                        i_gnt   = any_req & m_gnt;
                    end
                end
                BUSY_I:  i_rvalid = m_rvalid;
                BUSY_D:  d_rvalid = m_rvalid;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        reset    = 1'b1;
        i_req    = 1'b1;
        i_addr   = 32'h0000_0abc;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h0000_0def;
        d_wdata  = 32'h1111_2222;
        d_be     = 4'hf;
        m_gnt    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'hffff_ffff;
        #2;
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_gnts", 32'({i_gnt, d_gnt}), 32'd0);
        check("rst_rvalids", 32'({i_rvalid, d_rvalid}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        step();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        reset = 1'b0;
        step();

        // Single fetch
        i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
        settle();
        check("fetch_m_req", 32'(m_req), 32'd1);
        check("fetch_m_addr", m_addr, 32'h100);
        check("fetch_i_gnt", 32'(i_gnt), 32'd1);
        check("fetch_d_gnt", 32'(d_gnt), 32'd0);
        step();
        i_req = 1'b0; m_gnt = 1'b0;
        settle();
        check("fetch_busy_m_req", 32'(m_req), 32'd0);
        check("fetch_busy_rvalid", 32'(i_rvalid), 32'd0);
        step();
        m_rvalid = 1'b1; m_rdata = 32'hdead_beef;
        settle();
        check("fetch_i_rvalid", 32'(i_rvalid), 32'd1);
        check("fetch_i_rdata", i_rdata, 32'hdead_beef);
        check("fetch_d_rvalid", 32'(d_rvalid), 32'd0);
        step();
        m_rvalid = 1'b0;

        // Contention: data wins first
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; d_be = 4'h5;
        m_gnt = 1'b1;
        settle();
        check("cont_d_gnt", 32'(d_gnt), 32'd1);
        check("cont_i_gnt", 32'(i_gnt), 32'd0);
        check("cont_m_we", 32'(m_we), 32'd1);
        check("cont_m_addr", m_addr, 32'h200);
        check("cont_m_wdata", m_wdata, 32'h55);
        check("cont_m_be", 32'(m_be), 32'h5);
        step();
        d_req = 1'b0; d_we = 1'b0; m_gnt = 1'b0;
        settle();
        check("cont_busy_m_req", 32'(m_req), 32'd0);
        step();
        m_rvalid = 1'b1; m_rdata = 32'h0;
        m_gnt = 1'b1;
        settle();
        check("cont_d_rvalid", 32'(d_rvalid), 32'd1);
        check("cont_no_gnt_on_rvalid", 32'({i_gnt, d_gnt, m_req}), 32'd0);
        check("cont_i_rvalid", 32'(i_rvalid), 32'd0);
        step();
        m_rvalid = 1'b0;
        settle();
        check("cont_i_gnt_after", 32'(i_gnt), 32'd1);
        check("cont_i_addr_after", m_addr, 32'h300);
        step();
        i_req = 1'b0; m_gnt = 1'b0;
        step();
        m_rvalid = 1'b1;
        settle();
        check("cont_i_rvalid_after", 32'(i_rvalid), 32'd1);
        step();
        m_rvalid = 1'b0;

        // Starvation: D D D I D D D I
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_addr = 32'h400;
        for (int k = 0; k < 8; k++) begin
            m_gnt = 1'b1; m_rvalid = 1'b0;
            settle();
            check($sformatf("starve_gnt%0d", k), 32'({i_gnt, d_gnt}),
                  (k % 4 == 3) ? 32'd2 : 32'd1);
            step();
            m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'(k);
            settle();
            check($sformatf("starve_rv%0d", k), 32'({i_rvalid, d_rvalid}),
                  (k % 4 == 3) ? 32'd2 : 32'd1);
            step();
        end
        m_rvalid = 1'b0; i_req = 1'b0; d_req = 1'b0;

        // Lock: instruction owner held against a later data request
        i_req = 1'b1; i_addr = 32'h600; m_gnt = 1'b0;
        settle();
        check("lock_m_req", 32'(m_req), 32'd1);
        check("lock_m_addr0", m_addr, 32'h600);
        check("lock_i_gnt0", 32'(i_gnt), 32'd0);
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700;
        settle();
        check("lock_m_addr1", m_addr, 32'h600);
        check("lock_m_we1", 32'(m_we), 32'd0);
        step();
        step();
        settle();
        check("lock_m_addr3", m_addr, 32'h600);
        check("lock_d_gnt3", 32'(d_gnt), 32'd0);
        step();
        m_gnt = 1'b1;
        settle();
        check("lock_i_gnt", 32'(i_gnt), 32'd1);
        check("lock_d_gnt", 32'(d_gnt), 32'd0);
        step();
        i_req = 1'b0; m_gnt = 1'b0;
        step();
        m_rvalid = 1'b1;
        settle();
        check("lock_i_rvalid", 32'(i_rvalid), 32'd1);
        step();
        m_rvalid = 1'b0; m_gnt = 1'b1;
        settle();
        check("lock_then_d_gnt", 32'(d_gnt), 32'd1);
        check("lock_then_m_addr", m_addr, 32'h700);
        step();
        d_req = 1'b0; d_we = 1'b0; m_gnt = 1'b0;

        // Reset mid-operation in BUSY_D
        reset = 1'b1;
        settle();
        check("rst_busy_outputs", 32'({m_req, d_rvalid, i_rvalid}), 32'd0);
        step();
        reset = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hbad0_bad0;
        settle();
        check("rst_late_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_late_i_rvalid", 32'(i_rvalid), 32'd0);
        step();
        m_rvalid = 1'b0;
        d_req = 1'b1; d_addr = 32'h800; m_gnt = 1'b1;
        settle();
        check("rst_next_d_gnt", 32'(d_gnt), 32'd1);
        check("rst_next_m_addr", m_addr, 32'h800);
        step();
        d_req = 1'b0; m_gnt = 1'b0;
        step();
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        settle();
        check("rst_next_d_rvalid", 32'(d_rvalid), 32'd1);
        check("rst_next_d_rdata", d_rdata, 32'h1234_5678);
        step();

        // Stray response in IDLE
        m_rvalid = 1'b1;
        settle();
        check("stray_rvalids", 32'({i_rvalid, d_rvalid}), 32'd0);
        check("stray_m_req", 32'(m_req), 32'd0);
        step();
        // Grant and stray response together: grant only
        i_req = 1'b1; i_addr = 32'h900; m_gnt = 1'b1;
        settle();
        check("gnt_rv_i_gnt", 32'(i_gnt), 32'd1);
        check("gnt_rv_i_rvalid", 32'(i_rvalid), 32'd0);
        step();
        i_req = 1'b0; m_gnt = 1'b0;
        settle();
        check("gnt_rv_busy_rvalid", 32'(i_rvalid), 32'd1);
        step();
        m_rvalid = 1'b0;
        settle();
        check("gnt_rv_idle_m_req", 32'(m_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
